// File: rtl/aux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aux_pkg
// Purpose : Shared serializer state type and width helpers for aux_sampler.
// Revision: 1.0
// ============================================================================
package aux_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PUSH = 1'b1
    } ser_state_t;

    // Window sum width: one code plus log2 of the number of samples summed.
    function automatic int sum_w(input int code_w, input int decim_log2);
        return code_w + decim_log2;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aux_fifo.sv
`default_nettype none
// ============================================================================
// Module  : aux_fifo
// Purpose : First-word-fall-through FIFO; a write into a full FIFO succeeds
//           only when a pop happens in the same cycle.
// Revision: 1.0
// ============================================================================
module aux_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     nRES,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_FW = $clog2(DEPTH) + 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
            $error("aux_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_FW-1:0]  r_fill;
    logic             w_pop;
    logic             w_wr;

    assign empty = (r_fill == '0);
    assign full  = (r_fill == c_FW'(DEPTH));
    assign fill  = r_fill;
    assign w_pop = pop && !empty;
    assign w_wr  = wr_en && (!full || w_pop);

    // Head is forced to zero when empty so outputs are clean after reset.
    assign rd_data = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/aux_sampler.sv
`default_nettype none
// ============================================================================
// Module  : aux_sampler
// Purpose : Decimating multi-channel DAC code accumulator with a serialized,
//           FIFO-buffered output stream and sticky overflow flag.
// Revision: 1.0
// ============================================================================
module aux_sampler
    import aux_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int CODE_W     = 15,
    parameter int DECIM_LOG2 = 4,
    parameter int DEPTH      = 16
) (
    input  logic                                  CLK,
    input  logic                                  nRES,
    input  logic                                  EN,
    input  logic [NCH*CODE_W-1:0]                 CODE,
    output logic                                  OUT_VALID,
    input  logic                                  OUT_READY,
    output logic [idx_w(NCH)-1:0]                 OUT_CH,
    output logic [sum_w(CODE_W, DECIM_LOG2)-1:0]  OUT_DATA,
    output logic [$clog2(DEPTH):0]                FILL,
    output logic                                  OVF,
    input  logic                                  CLR_OVF
);

    localparam int c_SW = sum_w(CODE_W, DECIM_LOG2);
    localparam int c_IW = idx_w(NCH);
    localparam int c_WW = c_IW + c_SW;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(NCH - 1);

    // A burst of NCH pushes must finish before the next window can close.
    generate
        if (NCH > (1 << DECIM_LOG2)) begin : g_nch_chk
            $error("aux_sampler: NCH must not exceed 2**DECIM_LOG2");
        end
    endgenerate

    logic [DECIM_LOG2-1:0] r_phase;
    logic [c_SW-1:0]       r_acc  [NCH];
    logic [c_SW-1:0]       r_snap [NCH];
    logic [CODE_W-1:0]     w_code [NCH];
    logic                  w_snap;

    ser_state_t            r_state;
    ser_state_t            w_state_nxt;
    logic [c_IW-1:0]       r_idx;
    logic [c_IW-1:0]       w_idx_nxt;
    logic                  w_push;

    logic [c_WW-1:0]       w_wr_data;
    logic [c_WW-1:0]       w_rd_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_reject;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_code[k] = CODE[k*CODE_W +: CODE_W];
        end
    end

    assign w_snap = EN && (r_phase == '1);

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            r_phase <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_acc[k]  <= '0;
                r_snap[k] <= '0;
            end
        end else if (EN) begin
            r_phase <= r_phase + 1'b1;
            for (int k = 0; k < NCH; k++) begin
                if (w_snap) begin
                    r_snap[k] <= r_acc[k] + c_SW'(w_code[k]);
                    r_acc[k]  <= '0;
                end else begin
                    r_acc[k]  <= r_acc[k] + c_SW'(w_code[k]);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // A snapshot landing on the last push cycle chains straight into a new burst.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_snap) begin
                    w_state_nxt = S_PUSH;
                    w_idx_nxt   = '0;
                end
            end
            S_PUSH: begin
                w_push = 1'b1;
                if (r_idx == c_LAST) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = w_snap ? S_PUSH : S_IDLE;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign w_wr_data = {r_idx, r_snap[r_idx]};

    aux_fifo #(
        .WIDTH (c_WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .nRES    (nRES),
        .wr_en   (w_push),
        .wr_data (w_wr_data),
        .pop     (OUT_READY),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .fill    (FILL)
    );

    assign OUT_VALID = !w_empty;
    assign OUT_CH    = w_rd_data[c_WW-1 -: c_IW];
    assign OUT_DATA  = w_rd_data[c_SW-1:0];

    // Full FIFO implies a valid head, so only OUT_READY decides if room appears.
    assign w_reject = w_push && w_full && !OUT_READY;

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            OVF <= 1'b0;
        end else if (w_reject) begin
            OVF <= 1'b1;
        end else if (CLR_OVF) begin
            OVF <= 1'b0;
        end
    end

endmodule
`default_nettype wire
